// File: rtl/gravsim_regfile_pkg.sv
// gravsim_pkg: shared word map, state type and ACC range helpers for the
// N-body register file (G, NUM, START, DONE, then per-body field blocks).
package gravsim_pkg;

    localparam int MAX_BODIES = 10;
    localparam int NUM_WORDS  = 4 + 11 * MAX_BODIES;
    localparam int AVL_AW     = 7;

    localparam int W_G     = 0;
    localparam int W_NUM   = 1;
    localparam int W_START = 2;
    localparam int W_DONE  = 3;

    // Body i (1..MAX_BODIES) of a field lives at OFFSET_<field> + i.
    localparam int OFFSET_MASS  = 3;
    localparam int OFFSET_RAD   = 13;
    localparam int OFFSET_POS_X = 23;
    localparam int OFFSET_POS_Y = 33;
    localparam int OFFSET_POS_Z = 43;
    localparam int OFFSET_VEL_X = 53;
    localparam int OFFSET_VEL_Y = 63;
    localparam int OFFSET_VEL_Z = 73;
    localparam int OFFSET_ACC_X = 83;
    localparam int OFFSET_ACC_Y = 93;
    localparam int OFFSET_ACC_Z = 103;

    // First word software may not touch while the FSM runs.
    localparam int FIRST_BODY_WORD = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } rf_state_t;

    function automatic int acc_first();
        return OFFSET_ACC_X + 1;
    endfunction

    function automatic int acc_last();
        return OFFSET_ACC_Z + MAX_BODIES;
    endfunction

endpackage

// File: rtl/gravsim_regfile_if.sv
// gravsim_avl_if: Avalon-MM slave bundle between the NIOS master and the
// register file. master drives CS/READ/WRITE/BYTE_EN/ADDR/WRITEDATA,
// slave returns READDATA.
interface gravsim_avl_if;
    import gravsim_pkg::*;

    logic              AVL_CS;
    logic              AVL_READ;
    logic              AVL_WRITE;
    logic [3:0]        AVL_BYTE_EN;
    logic [AVL_AW-1:0] AVL_ADDR;
    logic [31:0]       AVL_WRITEDATA;
    logic [31:0]       AVL_READDATA;

    modport master (
        output AVL_CS,
        output AVL_READ,
        output AVL_WRITE,
        output AVL_BYTE_EN,
        output AVL_ADDR,
        output AVL_WRITEDATA,
        input  AVL_READDATA
    );

    modport slave (
        input  AVL_CS,
        input  AVL_READ,
        input  AVL_WRITE,
        input  AVL_BYTE_EN,
        input  AVL_ADDR,
        input  AVL_WRITEDATA,
        output AVL_READDATA
    );

endinterface

// File: rtl/gravsim_regfile_byte_merge.sv
// gravsim_byte_merge: combinational byte-enable merge of a 32-bit word.
// Ports: old_word (current), new_word (incoming), byte_en, merged (result).
module gravsim_byte_merge
    import gravsim_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  byte_en,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/gravsim_regfile.sv
// gravsim_regfile: word register file shared by the NIOS Avalon master and
// the N-body FSM; owns the START/DONE handshake.
// Ports: CLK, RESET (sync, active high); avl (Avalon slave, read latency 1);
//   FSM_we[1:0] (bit0 ports 1-3, bit1 ports 4-6), ADDR1..6/DATA1..6,
//   clear_accs, FSM_DONE in; FSM_START and registered datafile out.
// Option: GRAVSIM_RF_CYCLE_COUNTER_EN adds a RUN cycle counter at NUM_WORDS.
module gravsim_regfile
    import gravsim_pkg::*;
(
    input  logic                        CLK,
    input  logic                        RESET,
    gravsim_avl_if.slave                avl,
    input  logic [1:0]                  FSM_we,
    input  logic [31:0]                 ADDR1,
    input  logic [31:0]                 ADDR2,
    input  logic [31:0]                 ADDR3,
    input  logic [31:0]                 ADDR4,
    input  logic [31:0]                 ADDR5,
    input  logic [31:0]                 ADDR6,
    input  logic [31:0]                 DATA1,
    input  logic [31:0]                 DATA2,
    input  logic [31:0]                 DATA3,
    input  logic [31:0]                 DATA4,
    input  logic [31:0]                 DATA5,
    input  logic [31:0]                 DATA6,
    input  logic                        clear_accs,
    input  logic                        FSM_DONE,
    output logic                        FSM_START,
    output logic [NUM_WORDS-1:0][31:0]  datafile
);

    localparam int ACC_LO = acc_first();
    localparam int ACC_HI = acc_last();

    localparam logic [AVL_AW-1:0] A_NUM_WORDS = AVL_AW'(NUM_WORDS);
    localparam logic [AVL_AW-1:0] A_DONE      = AVL_AW'(W_DONE);
    localparam logic [AVL_AW-1:0] A_BODY      = AVL_AW'(FIRST_BODY_WORD);
    localparam logic [31:0]       F_NUM_WORDS = 32'(NUM_WORDS);

    logic [NUM_WORDS-1:0][31:0] mem_q;
    logic [NUM_WORDS-1:0][31:0] mem_w;
    logic [NUM_WORDS-1:0][31:0] mem_d;
    rf_state_t                  state_q;
    rf_state_t                  state_d;
    logic                       start_q;
    logic                       start_d;
    logic [31:0]                rdata_q;
    logic [31:0]                rdata_d;

    logic [31:0] fsm_addr [6];
    logic [31:0] fsm_data [6];
    logic [5:0]  fsm_en;

    logic        avl_in_range;
    logic        avl_wr_ok;
    logic [31:0] avl_cur;
    logic [31:0] avl_merged;
    logic [31:0] cyc_rd;

    assign fsm_addr = '{ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6};
    assign fsm_data = '{DATA1, DATA2, DATA3, DATA4, DATA5, DATA6};
    assign fsm_en   = {{3{FSM_we[1]}}, {3{FSM_we[0]}}};

    assign avl_in_range = avl.AVL_ADDR < A_NUM_WORDS;
    assign avl_cur      = avl_in_range ? mem_q[avl.AVL_ADDR] : '0;

    // DONE is handshake-owned; body words are frozen while the FSM runs.
    always_comb begin
        avl_wr_ok = avl.AVL_CS && avl.AVL_WRITE && avl_in_range;
        if (avl.AVL_ADDR == A_DONE) begin
            avl_wr_ok = 1'b0;
        end
        if (state_q == RUN && avl.AVL_ADDR >= A_BODY) begin
            avl_wr_ok = 1'b0;
        end
    end

    gravsim_byte_merge u_merge (
        .old_word (avl_cur),
        .new_word (avl.AVL_WRITEDATA),
        .byte_en  (avl.AVL_BYTE_EN),
        .merged   (avl_merged)
    );

    // Later assignments win: Avalon, then clear_accs, then FSM ports 1..6.
    always_comb begin
        mem_w = mem_q;
        if (avl_wr_ok) begin
            mem_w[avl.AVL_ADDR] = avl_merged;
        end
        if (clear_accs) begin
            for (int i = ACC_LO; i <= ACC_HI; i++) begin
                mem_w[i] = '0;
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (fsm_en[k] && fsm_addr[k] < F_NUM_WORDS) begin
                mem_w[fsm_addr[k][AVL_AW-1:0]] = fsm_data[k];
            end
        end
    end

    // START is sampled from the stored word so FSM_START rises one cycle
    // after the write lands; clearing START takes effect on the write edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_q[W_START][0] && mem_w[W_START][0]) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!mem_w[W_START][0]) begin
                    state_d = IDLE;
                end else if (FSM_DONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!mem_w[W_START][0]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        start_d = (state_d != IDLE);
    end

    always_comb begin
        mem_d         = mem_w;
        mem_d[W_DONE] = {31'b0, state_d == DONE};
    end

`ifdef GRAVSIM_RF_CYCLE_COUNTER_EN
    logic [31:0] cyc_q;
    logic [31:0] cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == IDLE && state_d == RUN) begin
            cyc_d = '0;
        end else if (state_q == RUN && cyc_q != '1) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cyc_rd = cyc_q;
`else
    assign cyc_rd = '0;
`endif

    always_comb begin
        rdata_d = rdata_q;
        if (avl.AVL_CS && avl.AVL_READ) begin
            if (avl_in_range) begin
                rdata_d = avl_cur;
            end else if (avl.AVL_ADDR == A_NUM_WORDS) begin
                rdata_d = cyc_rd;
            end else begin
                rdata_d = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_q   <= '0;
            state_q <= IDLE;
            start_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            state_q <= state_d;
            start_q <= start_d;
            rdata_q <= rdata_d;
        end
    end

    assign datafile         = mem_q;
    assign FSM_START        = start_q;
    assign avl.AVL_READDATA = rdata_q;

endmodule

// File: tb/tb_gravsim_regfile.sv
// tb_gravsim_regfile: directed self-checking bench for gravsim_regfile.
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_gravsim_regfile;
    import gravsim_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    logic [1:0] FSM_we;
    logic [31:0] ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6;
    logic [31:0] DATA1, DATA2, DATA3, DATA4, DATA5, DATA6;
    logic clear_accs;
    logic FSM_DONE;
    logic FSM_START;
    logic [NUM_WORDS-1:0][31:0] datafile;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    gravsim_avl_if avl ();

    gravsim_regfile dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .avl        (avl),
        .FSM_we     (FSM_we),
        .ADDR1      (ADDR1),
        .ADDR2      (ADDR2),
        .ADDR3      (ADDR3),
        .ADDR4      (ADDR4),
        .ADDR5      (ADDR5),
        .ADDR6      (ADDR6),
        .DATA1      (DATA1),
        .DATA2      (DATA2),
        .DATA3      (DATA3),
        .DATA4      (DATA4),
        .DATA5      (DATA5),
        .DATA6      (DATA6),
        .clear_accs (clear_accs),
        .FSM_DONE   (FSM_DONE),
        .FSM_START  (FSM_START),
        .datafile   (datafile)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle();
        avl.AVL_CS        = 1'b0;
        avl.AVL_READ      = 1'b0;
        avl.AVL_WRITE     = 1'b0;
        avl.AVL_BYTE_EN   = 4'h0;
        avl.AVL_ADDR      = '0;
        avl.AVL_WRITEDATA = '0;
        FSM_we     = 2'b00;
        ADDR1 = '1; ADDR2 = '1; ADDR3 = '1;
        ADDR4 = '1; ADDR5 = '1; ADDR6 = '1;
        DATA1 = '0; DATA2 = '0; DATA3 = '0;
        DATA4 = '0; DATA5 = '0; DATA6 = '0;
        clear_accs = 1'b0;
        FSM_DONE   = 1'b0;
    endtask

    task automatic set_wr(input int a, input logic [31:0] d,
                          input logic [3:0] be);
        avl.AVL_CS        = 1'b1;
        avl.AVL_WRITE     = 1'b1;
        avl.AVL_ADDR      = 7'(a);
        avl.AVL_WRITEDATA = d;
        avl.AVL_BYTE_EN   = be;
    endtask

    task automatic avl_wr(input int a, input logic [31:0] d,
                          input logic [3:0] be);
        set_wr(a, d, be);
        tick();
        bus_idle();
    endtask

    task automatic avl_rd(input int a, output logic [31:0] d);
        avl.AVL_CS   = 1'b1;
        avl.AVL_READ = 1'b1;
        avl.AVL_ADDR = 7'(a);
        tick();
        d = avl.AVL_READDATA;
        bus_idle();
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < NUM_WORDS; i++) begin
            chk($sformatf("%s_w%0d", tag, i), datafile[i], 32'h0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        bus_idle();
        RESET = 1'b1;
        repeat (10) tick();
        chk_zero("rst");
        chk("rst_start", {31'b0, FSM_START}, 32'd0);
        chk("rst_rdata", avl.AVL_READDATA, 32'd0);
        RESET = 1'b0;

        avl_wr(0, 32'hFFFF_FFFF, 4'hF);
        avl_wr(0, 32'h4080_0000, 4'b0011);
        chk("be_lo", datafile[0], 32'hFFFF_0000);
        avl_wr(0, 32'h4080_0000, 4'b1100);
        chk("be_hi", datafile[0], 32'h4080_0000);
        avl_rd(0, rd);
        chk("rd_g", rd, 32'h4080_0000);

        avl_wr(3, 32'h5, 4'hF);
        chk("done_ro", datafile[3], 32'h0);
        avl_rd(120, rd);
        chk("rd_oor", rd, 32'h0);
        avl_wr(4, 32'h11, 4'hF);
        chk("idle_wr4", datafile[4], 32'h11);

        set_wr(10, 32'h55, 4'hF);
        FSM_we = 2'b01;
        ADDR1  = 32'd10;
        DATA1  = 32'h66;
        tick();
        bus_idle();
        chk("fsm_gt_avl", datafile[10], 32'h66);

        for (int a = 83; a <= 113; a++) begin
            avl_wr(a, 32'hBF80_0000, 4'hF);
        end
        chk("acc_pre", datafile[100], 32'hBF80_0000);

        clear_accs = 1'b1;
        set_wr(90, 32'h1234, 4'hF);
        FSM_we = 2'b10;
        ADDR4  = 32'd86;
        DATA4  = 32'h77;
        tick();
        bus_idle();
        chk("clr_84", datafile[84], 32'h0);
        chk("clr_99", datafile[99], 32'h0);
        chk("clr_113", datafile[113], 32'h0);
        chk("clr_gt_avl", datafile[90], 32'h0);
        chk("fsm_gt_clr", datafile[86], 32'h77);
        chk("clr_83", datafile[83], 32'hBF80_0000);

        avl_wr(2, 32'h1, 4'hF);
        chk("start_land", datafile[2], 32'h1);
        chk("start_lat", {31'b0, FSM_START}, 32'd0);
        tick();
        chk("start_on", {31'b0, FSM_START}, 32'd1);

        FSM_we = 2'b11;
        ADDR1 = 32'd24; ADDR2 = 32'd54; ADDR3 = 32'd84;
        ADDR4 = 32'd25; ADDR5 = 32'd55; ADDR6 = 32'd85;
        DATA1 = 32'h3F80_0000; DATA2 = 32'h3F80_0000;
        DATA3 = 32'h3F80_0000; DATA4 = 32'h3F80_0000;
        DATA5 = 32'h3F80_0000; DATA6 = 32'h3F80_0000;
        set_wr(24, 32'hDEAD_BEEF, 4'hF);
        tick();
        bus_idle();
        chk("fsm_24", datafile[24], 32'h3F80_0000);
        chk("fsm_54", datafile[54], 32'h3F80_0000);
        chk("fsm_84", datafile[84], 32'h3F80_0000);
        chk("fsm_25", datafile[25], 32'h3F80_0000);
        chk("fsm_55", datafile[55], 32'h3F80_0000);
        chk("fsm_85", datafile[85], 32'h3F80_0000);

        FSM_we = 2'b01;
        ADDR1 = 32'd30;  DATA1 = 32'h1;
        ADDR2 = 32'd30;  DATA2 = 32'h2;
        ADDR3 = 32'd200; DATA3 = 32'h3;
        ADDR4 = 32'd31;  DATA4 = 32'h4;
        tick();
        bus_idle();
        chk("port_conf", datafile[30], 32'h2);
        chk("grp_dis", datafile[31], 32'h0);

        FSM_we = 2'b11;
        ADDR2 = 32'd32; DATA2 = 32'hA;
        ADDR5 = 32'd32; DATA5 = 32'hB;
        tick();
        bus_idle();
        chk("port_hi_win", datafile[32], 32'hB);

        avl_wr(5, 32'hAA, 4'hF);
        chk("run_ro5", datafile[5], 32'h0);
        avl_wr(0, 32'h42, 4'hF);
        chk("run_g", datafile[0], 32'h42);

        FSM_DONE = 1'b1;
        tick();
        bus_idle();
        chk("done_w3", datafile[3], 32'h1);
        chk("done_start", {31'b0, FSM_START}, 32'd1);
        avl_rd(3, rd);
        chk("rd_done", rd, 32'h1);

        avl_wr(2, 32'h0, 4'hF);
        chk("ack_start", {31'b0, FSM_START}, 32'd0);
        chk("ack_w3", datafile[3], 32'h0);
        FSM_DONE = 1'b1;
        tick();
        bus_idle();
        chk("idle_fdone", datafile[3], 32'h0);
        chk("idle_start", {31'b0, FSM_START}, 32'd0);

        avl_wr(2, 32'h1, 4'hF);
        tick();
        chk("abort_on", {31'b0, FSM_START}, 32'd1);
        avl_wr(2, 32'h0, 4'hF);
        chk("abort_start", {31'b0, FSM_START}, 32'd0);
        chk("abort_w3", datafile[3], 32'h0);
        tick();
        chk("abort_stay", {31'b0, FSM_START}, 32'd0);

        avl_wr(2, 32'h1, 4'hF);
        tick();
        chk("rr_on", {31'b0, FSM_START}, 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk_zero("rst_run");
        chk("rr_start", {31'b0, FSM_START}, 32'd0);
        tick();
        chk("rr_stay", {31'b0, FSM_START}, 32'd0);

`ifdef GRAVSIM_RF_CYCLE_COUNTER_EN
        avl_wr(2, 32'h1, 4'hF);
        tick();
        chk("cyc_on", {31'b0, FSM_START}, 32'd1);
        repeat (49) tick();
        FSM_DONE = 1'b1;
        tick();
        bus_idle();
        repeat (3) tick();
        avl_rd(114, rd);
        chk("cyc_50", rd, 32'd50);
        avl_wr(114, 32'h7, 4'hF);
        avl_rd(114, rd);
        chk("cyc_ro", rd, 32'd50);
`else
        avl_rd(114, rd);
        chk("no_cyc", rd, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gravsim_regfile.md
Name: gravsim_regfile

Overview:
- Shared word-addressed register file between the NIOS Avalon-MM master and the N-body compute FSM.
- Holds G, body count, START/DONE control words and the per-body mass/radius/pos/vel/acc words.
- Presents the whole array in parallel to the FSM as `datafile`.
- Consumes the FSM's write-back ports (FSM_we, ADDR1..6, DATA1..6), clear_accs and FSM_DONE, and owns the START/DONE handshake.

Parameters:
- MAX_BODIES, 10, number of body slots (bodies indexed 1..MAX_BODIES).
- NUM_WORDS, 4+11*MAX_BODIES (=114), storage depth in 32-bit words.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- AVL_CS  in  1  Avalon chip select
- AVL_READ  in  1  Avalon read strobe
- AVL_WRITE  in  1  Avalon write strobe
- AVL_BYTE_EN  in  4  Avalon byte enables
- AVL_ADDR  in  7  Avalon word address
- AVL_WRITEDATA  in  32  Avalon write data
- AVL_READDATA  out  32  Avalon read data, registered
- FSM_we  in  2  bit0 enables ports 1-3, bit1 enables ports 4-6
- ADDR1..ADDR6  in  32 each  FSM write word addresses
- DATA1..DATA6  in  32 each  FSM write data
- clear_accs  in  1  zero all ACC words this cycle
- FSM_DONE  in  1  FSM completion indication
- FSM_START  out  1  run request to FSM
- datafile  out  NUM_WORDS x 32  parallel view of all words, registered

Behaviour:
- Word map (shared package):
  - 0 = G, 1 = NUM, 2 = START, 3 = DONE.
  - Per-field base offsets: MASS 3, RAD 13, POS_X/Y/Z 23/33/43, VEL_X/Y/Z 53/63/73, ACC_X/Y/Z 83/93/103.
  - Body i occupies word base+i.
- Reset (RESET high at a CLK edge): all words 0, state IDLE, FSM_START 0, AVL_READDATA 0.
- Avalon read:
  - AVL_CS&AVL_READ returns the word on AVL_READDATA at the next edge (latency 1).
  - Addresses ≥ NUM_WORDS read 0.
- Avalon write:
  - AVL_CS&AVL_WRITE merges each enabled byte into the word at the next edge.
  - Addresses ≥ NUM_WORDS are ignored.
  - Word 3 (DONE) is read-only to software.
  - In RUN, writes to words ≥4 are ignored; words 0..2 stay writable.
- FSM writes:
  - Port k writes full 32 bits to ADDRk when its group enable is set.
  - Out-of-range ADDRk is ignored.
  - Same-address conflict among ports: highest-numbered port wins.
- clear_accs: words 84..113 take 0 next edge.
- Priority per word, same cycle: FSM port write > clear_accs > Avalon write.
- State machine, states IDLE / RUN / DONE:
  - IDLE→RUN: when word 2 bit0 becomes 1. FSM_START=1 registered, asserted the cycle after the START write lands.
  - RUN→DONE: on FSM_DONE high. Word 3 := 1.
  - DONE→IDLE: when software writes word 2 bit0 = 0. FSM_START drops and word 3 := 0 on the same edge.
  - Clearing START in RUN: RUN→IDLE, FSM_START drops, DONE stays 0; the FSM must abort.
  - FSM_DONE in IDLE or DONE is ignored.
  - FSM_START holds 1 in RUN and DONE.
- datafile reflects every write one edge after it.
- RESET mid-RUN: immediate return to IDLE with all words cleared.

Optional Feature:
- Macro: GRAVSIM_RF_CYCLE_COUNTER_EN.
- When defined:
  - 32-bit cycle counter, cleared on IDLE→RUN and incremented each cycle in RUN.
  - Frozen in DONE/IDLE; saturates at 0xFFFFFFFF.
  - Readable at Avalon word address NUM_WORDS (114); writes ignored.
- When undefined: no counter; address 114 reads 0.

Decomposition:
- Package gravsim_pkg holds:
  - the OFFSET_* constants, MAX_BODIES and NUM_WORDS;
  - the rf_state_t enum {IDLE, RUN, DONE};
  - a function giving the ACC word range.
- One natural sub-module, gravsim_byte_merge: combinational 32-bit byte-enable merge used by the Avalon write path.

Test Plan:
- RESET 10 cycles → all datafile words 0, FSM_START 0, AVL_READDATA 0.
- Avalon write 0x40800000 to addr 0 with BE=4'b0011, then BE=4'b1100 → read addr 0 returns 0x40800000 one cycle after READ.
- Write 1 to addr 2 → FSM_START high next cycle. FSM_we=2'b11 writing 0x3F800000 to addrs 24,54,84,25,55,85 → datafile shows them. Simultaneous Avalon write to 24 → FSM value wins.
- clear_accs with ACC words preset to 0xBF800000 → words 84..113 read 0, word 83 unchanged.
- FSM_DONE pulse in RUN → word 3 reads 1. Write 0 to addr 2 → FSM_START 0, word 3 reads 0. Second FSM_DONE in IDLE → word 3 stays 0.
- RESET asserted mid-RUN → next edge all words 0, FSM_START 0. With GRAVSIM_RF_CYCLE_COUNTER_EN, 50 RUN cycles then DONE → addr 114 reads 50.
